// File: rtl/dds_sample_capture.sv
// Triggered {tri,sine} capture buffer: arm, wait for a rising sine zero crossing, store DEPTH
// decimated pairs, then drain over valid/ready. Optional trigger timeout: DDS_CAP_TIMEOUT_EN.
module dds_sample_capture #(
  parameter int SINE_W  = 16,
  parameter int TRI_W   = 17,
  parameter int DEPTH   = 256,
  parameter int DECIM_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic [DECIM_W-1:0]       decim,
  input  logic                     sample_en,
  input  logic signed [SINE_W-1:0] sine_in,
  input  logic signed [TRI_W-1:0]  tri_in,
  output logic [TRI_W+SINE_W-1:0]  out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
`ifdef DDS_CAP_TIMEOUT_EN
  ,
  output logic                     timed_out
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = TRI_W + SINE_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]         state;
  logic [SINE_W-1:0]  prev_sine;
  logic               prev_valid;
  logic [DECIM_W-1:0] decim_q;
  logic [DECIM_W-1:0] dec_cnt;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      xfer_cnt;
  logic               fetch_done;
  logic               rdq_valid;
  logic [DW-1:0]      rdq;
  logic [DW-1:0]      mem [DEPTH];

  logic          trig_raw;
  logic          trig;
  logic          to_hit;
  logic          wait_wr;
  logic          fill_wr;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic          out_adv;
  logic          rd_en;
  logic          xfer;

`ifdef DDS_CAP_TIMEOUT_EN
  logic [15:0] to_cnt;
`endif

  // Rising crossing: previous sample negative, current one non-negative (sign bits only).
  always_comb begin
    trig_raw = sample_en && prev_valid && prev_sine[SINE_W-1] && !sine_in[SINE_W-1];
`ifdef DDS_CAP_TIMEOUT_EN
    to_hit   = sample_en && (to_cnt == 16'hFFFF);
`else
    to_hit   = 1'b0;
`endif
    trig     = trig_raw || to_hit;
    wait_wr  = (state == S_WAIT) && trig;
    fill_wr  = (state == S_FILL) && sample_en && (dec_cnt == '0);
    mem_we   = wait_wr || fill_wr;
    mem_addr = wait_wr ? '0 : wr_ptr;
    // Stream: a word moves when out_valid && out_ready; out_data/out_valid hold otherwise.
    out_adv  = !out_valid || out_ready;
    rd_en    = (state == S_DRAIN) && !fetch_done && (!rdq_valid || out_adv);
    xfer     = (state == S_DRAIN) && out_valid && out_ready;
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= {tri_in, sine_in};
    if (rd_en)  rdq <= mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      prev_sine  <= '0;
      prev_valid <= 1'b0;
      decim_q    <= '0;
      dec_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      xfer_cnt   <= '0;
      fetch_done <= 1'b0;
      rdq_valid  <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
`ifdef DDS_CAP_TIMEOUT_EN
      to_cnt     <= '0;
      timed_out  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (sample_en) begin
        prev_sine  <= sine_in;
        prev_valid <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (arm) begin
            decim_q    <= decim;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            xfer_cnt   <= '0;
            fetch_done <= 1'b0;
            rdq_valid  <= 1'b0;
            state      <= S_WAIT;
`ifdef DDS_CAP_TIMEOUT_EN
            to_cnt     <= '0;
            timed_out  <= 1'b0;
`endif
          end
        end
        S_WAIT: begin
          if (trig) begin
            wr_ptr  <= AW'(1);
            dec_cnt <= decim_q;
            state   <= S_FILL;
`ifdef DDS_CAP_TIMEOUT_EN
            timed_out <= !trig_raw;
          end else if (sample_en) begin
            to_cnt <= to_cnt + 16'd1;
`endif
          end
        end
        S_FILL: begin
          if (sample_en) begin
            if (dec_cnt == '0) begin
              wr_ptr  <= wr_ptr + AW'(1);
              dec_cnt <= decim_q;
              if (wr_ptr == AW'(DEPTH - 1)) state <= S_DRAIN;
            end else begin
              dec_cnt <= dec_cnt - DECIM_W'(1);
            end
          end
        end
        default: begin
          // Two-stage read path: RAM output register (rdq) feeds the output register.
          if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
            if (rd_ptr == AW'(DEPTH - 1)) fetch_done <= 1'b1;
          end
          if (rd_en)        rdq_valid <= 1'b1;
          else if (out_adv) rdq_valid <= 1'b0;
          if (out_adv) begin
            out_valid <= rdq_valid;
            if (rdq_valid) out_data <= rdq;
          end
          if (xfer) begin
            xfer_cnt <= xfer_cnt + AW'(1);
            if (xfer_cnt == AW'(DEPTH - 1)) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule
